// File: rtl/fp16_dot_seq.sv
// Dot-product sequencer for fp16_mac: feeds one operand pair at a time with the
// running sum, waits out the MAC latency, and returns the sum at the end of a vector.
module fp16_dot_seq #(
  parameter int MAC_LAT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_last,
  output logic [15:0] mac_in1,
  output logic [15:0] mac_in2,
  output logic [15:0] mac_acc,
  input  logic [15:0] mac_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [15:0] out_count
);

  localparam int CW = $clog2(MAC_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t          state, state_nxt;
  logic [15:0]     acc;
  logic [15:0]     len;
  logic [15:0]     op_a;
  logic [15:0]     op_b;
  logic            last_q;
  logic [CW-1:0]   cnt;
  logic            lat_done;

  assign lat_done = (cnt == CW'(MAC_LAT));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      len    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      last_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a   <= in_a;
            op_b   <= in_b;
            last_q <= in_last;
          end
        end
        ISSUE: begin
          cnt <= CW'(1);
          if (len != 16'hFFFF) len <= len + 16'd1;
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          if (lat_done) acc <= mac_res;
        end
        OUT: begin
          if (out_ready) begin
            acc <= '0;
            len <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    mac_in1   = '0;
    mac_in2   = '0;
    mac_acc   = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_count = '0;
    case (state)
      IDLE: begin
        if (in_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        mac_in1   = op_a;
        mac_in2   = op_b;
        mac_acc   = acc;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (lat_done) state_nxt = last_q ? OUT : IDLE;
      end
      OUT: begin
        out_valid = 1'b1;
        out_data  = acc;
        out_count = len;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset forces the state to IDLE, so gate ready to keep it low while reset is held.
  assign in_ready = (state == IDLE) && !rst;

endmodule

// File: tb/tb_fp16_dot_seq.sv
// Self-checking bench for fp16_dot_seq with a behavioural fp16_mac model and
// a result scoreboard.
module tb_fp16_dot_seq;

  localparam int MAC_LAT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_last;
  logic [15:0] mac_in1;
  logic [15:0] mac_in2;
  logic [15:0] mac_acc;
  logic [15:0] mac_res;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] out_count;

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] count;
  } result_t;

  result_t     sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_acc;
  logic [15:0] exp_len;

  always #5 clk = ~clk;

  fp16_dot_seq #(.MAC_LAT(MAC_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .mac_in1   (mac_in1),
    .mac_in2   (mac_in2),
    .mac_acc   (mac_acc),
    .mac_res   (mac_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else        repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp16_to_real(input logic [15:0] h);
    real v;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) v = real'(int'(h[9:0])) * pow2(-24);
    else        v = real'(int'({1'b1, h[9:0]})) * pow2(e - 25);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] real_to_fp16(input real r);
    real  a;
    int   e;
    int   m;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = int'((a - 1.0) * 1024.0);
    if (m == 1024) begin m = 0; e++; end
    return {s, e[4:0], m[9:0]};
  endfunction

  function automatic logic [15:0] mac_model(input logic [15:0] a, b, c);
    return real_to_fp16(fp16_to_real(a) * fp16_to_real(b) + fp16_to_real(c));
  endfunction

  // Behavioural MAC: result visible MAC_LAT edges after the operands are sampled.
  logic [15:0] mac_pipe [MAC_LAT];
  always @(posedge clk) begin
    mac_pipe[0] <= mac_model(mac_in1, mac_in2, mac_acc);
    for (int i = 1; i < MAC_LAT; i++) mac_pipe[i] <= mac_pipe[i-1];
  end
  assign mac_res = mac_pipe[MAC_LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Handshake one pair in, then verify the ISSUE cycle and update the model.
  task automatic accept_pair(input logic [15:0] a, input logic [15:0] b,
                             input logic last, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    check("accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_a     = 16'hDEAD;
    in_b     = 16'hBEEF;
    in_last  = 1'b0;
    check("issue_in1", 32'(mac_in1), 32'(a));
    check("issue_in2", 32'(mac_in2), 32'(b));
    check("issue_acc", 32'(mac_acc), 32'(exp_acc));
    check("issue_ready", 32'(in_ready), 32'd0);
    exp_acc = mac_model(a, b, exp_acc);
    if (exp_len != 16'hFFFF) exp_len = exp_len + 16'd1;
    if (last) begin
      sb_q.push_back('{data: exp_acc, count: exp_len});
      exp_acc = 16'h0000;
      exp_len = 16'h0000;
    end
  endtask

  // Walk the WAIT cycles, optionally toggling in_valid with junk data.
  task automatic finish_pair(input logic last, input bit noisy);
    for (int i = 1; i <= MAC_LAT; i++) begin
      tick();
      check("wait_ready", 32'(in_ready), 32'd0);
      check("wait_out_valid", 32'(out_valid), 32'd0);
      if (noisy) begin
        in_valid = 1'($urandom_range(0, 1));
        in_a     = 16'($urandom);
      end
    end
    tick();
    in_valid = 1'b0;
    if (last) begin
      check("out_valid_rise", 32'(out_valid), 32'd1);
    end else begin
      check("ready_return", 32'(in_ready), 32'd1);
      check("no_out_valid", 32'(out_valid), 32'd0);
    end
  endtask

  task automatic get_result(input int hold);
    result_t e;
    int      n;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    check("out_valid_seen", 32'(out_valid), 32'd1);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else                 e = 'x;
    check("out_data", 32'(out_data), 32'(e.data));
    check("out_count", 32'(out_count), 32'(e.count));
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'(e.data));
      check("bp_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_ready", 32'(in_ready), 32'd1);
    check("post_data", 32'(out_data), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    exp_acc   = 16'h0000;
    exp_len   = 16'h0000;

    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mac_acc", 32'(mac_acc), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_out_data", 32'(out_data), 32'd0);

    // Two-element vector: 1*2 + 2*3 = 8.0, mac_acc 0x0000 then 0x4000.
    accept_pair(16'h3C00, 16'h4000, 1'b0, 0);
    finish_pair(1'b0, 1'b0);
    accept_pair(16'h4000, 16'h4200, 1'b1, 0);
    finish_pair(1'b1, 1'b0);
    get_result(0);

    // Single element after an idle gap: out_valid exactly MAC_LAT+2 after accept.
    accept_pair(16'h4000, 16'h4200, 1'b1, 2);
    finish_pair(1'b1, 1'b0);
    get_result(0);

    // Backpressure for 10 cycles, then a vector that proves acc was cleared.
    accept_pair(16'h4000, 16'h4200, 1'b1, 0);
    finish_pair(1'b1, 1'b0);
    get_result(10);
    accept_pair(16'h3800, 16'h4000, 1'b1, 0);
    finish_pair(1'b1, 1'b0);
    get_result(0);

    // Gapped input over four 1.0*1.0 pairs with junk toggling during WAIT.
    for (int i = 0; i < 4; i++) begin
      accept_pair(16'h3C00, 16'h3C00, 1'(i == 3), int'($urandom_range(0, 3)));
      finish_pair(1'(i == 3), 1'b1);
    end
    get_result(0);

    // Reset in the third WAIT cycle discards the in-flight element.
    accept_pair(16'h4000, 16'h4000, 1'b1, 0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_mac_in1", 32'(mac_in1), 32'd0);
    sb_q.delete();
    exp_acc = 16'h0000;
    exp_len = 16'h0000;
    tick();
    rst = 1'b0;
    tick();
    check("midrst_rel_ready", 32'(in_ready), 32'd1);
    check("midrst_rel_valid", 32'(out_valid), 32'd0);
    accept_pair(16'h3C00, 16'h3C00, 1'b1, 0);
    finish_pair(1'b1, 1'b0);
    get_result(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
